// File: rtl/fb_rf_wr_arbiter.sv
// fb_rf_wr_arbiter: shares the single regfile write port between the ALU (req0)
// and the load unit (req1), registers the winning write one cycle, and keeps a
// per-register pending-write scoreboard (busy_vec) for the issue stage.
//
// Build option:
//   FB_WB_RR_EN defined   -> round-robin arbitration (PRI0/PRI1 state machine)
//   FB_WB_RR_EN undefined -> fixed priority, req0 always wins, no state register
//
// Register x0 is hardwired: writes to it are accepted but never drive rf_we,
// and its scoreboard bit is never set.
module fb_rf_wr_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [AW-1:0]        req0_addr,
    input  logic [XLEN-1:0]      req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [AW-1:0]        req1_addr,
    input  logic [XLEN-1:0]      req1_data,
    output logic                 req1_ready,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_addr,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [(2**AW)-1:0]   busy_vec
);

    localparam int unsigned NREG = 2**AW;

    // Write-back payload carried from a requester to the output stage.
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    wb_req_t         req0_pl;
    wb_req_t         req1_pl;
    wb_req_t         win_pl;
    logic            grant0_c;
    logic            grant1_c;
    logic            xfer_c;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    assign req0_pl = {req0_addr, req0_data};
    assign req1_pl = {req1_addr, req1_data};

`ifdef FB_WB_RR_EN
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_state_t;

    pri_state_t state_q;
    pri_state_t state_d;

    // Priority state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PRI0;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin grant: favoured side wins a tie; the loser is favoured next.
    always_comb begin
        state_d  = state_q;
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        case (state_q)
            PRI0: begin
                if (req0_valid) begin
                    grant0_c = 1'b1;
                end else if (req1_valid) begin
                    grant1_c = 1'b1;
                end
            end
            PRI1: begin
                if (req1_valid) begin
                    grant1_c = 1'b1;
                end else if (req0_valid) begin
                    grant0_c = 1'b1;
                end
            end
            default: begin
                state_d = PRI0;
            end
        endcase
        if (grant0_c) begin
            state_d = PRI1;
        end else if (grant1_c) begin
            state_d = PRI0;
        end
    end
`else
    // Fixed priority: req1 only gets the port on cycles req0 is idle.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (req0_valid) begin
            grant0_c = 1'b1;
        end else if (req1_valid) begin
            grant1_c = 1'b1;
        end
    end
`endif

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;
    assign xfer_c     = grant0_c | grant1_c;
    assign win_pl     = grant0_c ? req0_pl : req1_pl;

    // Output stage: register the accepted write; x0 writes never raise rf_we.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (xfer_c) begin
            rf_we    <= (win_pl.addr != '0);
            rf_waddr <= win_pl.addr;
            rf_wdata <= win_pl.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Scoreboard update: clear on the write cycle, a same-edge issue overrides.
    always_comb begin
        busy_d = busy_q;
        if (rf_we) begin
            busy_d[rf_waddr] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_fb_rf_wr_arbiter.sv
// Bench for fb_rf_wr_arbiter: directed vector table, hand-written scoreboard
// and reset sequences, then randomized traffic against a reference model.
module tb_fb_rf_wr_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid;
    logic [AW-1:0]   req0_addr;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [AW-1:0]   req1_addr;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_addr;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] busy_vec;

    always #5 clk = ~clk;

    fb_rf_wr_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy_vec   (busy_vec)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                         input logic iv, input logic [AW-1:0] ia);
        req0_valid  = v0;
        req0_addr   = a0;
        req0_data   = d0;
        req1_valid  = v1;
        req1_addr   = a1;
        req1_data   = d1;
        issue_valid = iv;
        issue_addr  = ia;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Single-cycle vector: inputs plus expected readies this cycle and
    // expected write-port values after the following edge.
    typedef struct {
        logic            r0v;
        logic [AW-1:0]   r0a;
        logic [XLEN-1:0] r0d;
        logic            r1v;
        logic [AW-1:0]   r1a;
        logic [XLEN-1:0] r1d;
        logic            e_r0;
        logic            e_r1;
        logic            e_we;
        logic [AW-1:0]   e_waddr;
        logic [XLEN-1:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(input logic r0v, input logic [AW-1:0] r0a, input logic [XLEN-1:0] r0d,
                                input logic r1v, input logic [AW-1:0] r1a, input logic [XLEN-1:0] r1d,
                                input logic e_r0, input logic e_r1, input logic e_we,
                                input logic [AW-1:0] e_waddr, input logic [XLEN-1:0] e_wdata);
        vec_t v;
        v.r0v = r0v; v.r0a = r0a; v.r0d = r0d;
        v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_we = e_we;
        v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        return v;
    endfunction

    vec_t vecs[10];

    // Reference model state (write port, scoreboard, who was granted last).
    logic            m_we;
    logic [AW-1:0]   m_waddr;
    logic [XLEN-1:0] m_wdata;
    logic [NREG-1:0] m_busy;
    int              m_last;

    // Pending requester transactions for the random phase.
    logic            p0v, p1v;
    logic [AW-1:0]   p0a, p1a;
    logic [XLEN-1:0] p0d, p1d;

    initial begin
        reset = 1'b0;
        drive_idle();

        vecs[0] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[1] = mk(1'b1, 5'd8, 32'h4, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h4);
        vecs[2] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd8, 32'h4);
        vecs[3] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h5, 1'b0, 1'b1, 1'b1, 5'd9, 32'h5);
        for (int i = 4; i < 8; i++) begin
`ifdef FB_WB_RR_EN
            if ((i % 2) == 0)
                vecs[i] = mk(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA);
            else
                vecs[i] = mk(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, 1'b1, 1'b1, 5'd4, 32'hB);
`else
            vecs[i] = mk(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA);
`endif
        end
        vecs[8] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF);
        vecs[9] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF);

        // Reset release with no requests.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("idle_we",   64'(rf_we),      64'(0));
            check("idle_busy", 64'(busy_vec),   64'(0));
            check("idle_rdy0", 64'(req0_ready), 64'(0));
            check("idle_rdy1", 64'(req1_ready), 64'(0));
        end

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].r0v, vecs[i].r0a, vecs[i].r0d, vecs[i].r1v, vecs[i].r1a, vecs[i].r1d, 1'b0, 5'd0);
            #1;
            check($sformatf("vec%0d_rdy0", i), 64'(req0_ready), 64'(vecs[i].e_r0));
            check($sformatf("vec%0d_rdy1", i), 64'(req1_ready), 64'(vecs[i].e_r1));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_we", i),    64'(rf_we),    64'(vecs[i].e_we));
            check($sformatf("vec%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].e_waddr));
            check($sformatf("vec%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].e_wdata));
            check($sformatf("vec%0d_busy", i),  64'(busy_vec), 64'(0));
        end

        // Scoreboard: set, then cleared one edge after the write.
        @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        @(posedge clk); #1;
        check("sb_set7", 64'(busy_vec), 64'(32'h80));
        @(negedge clk); drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        check("sb_wr_rdy0", 64'(req0_ready), 64'(1));
        @(posedge clk); #1;
        check("sb_wr_we",    64'(rf_we),    64'(1));
        check("sb_wr_waddr", 64'(rf_waddr), 64'(7));
        check("sb_still_busy", 64'(busy_vec), 64'(32'h80));
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        check("sb_cleared", 64'(busy_vec), 64'(0));
        check("sb_we_low",  64'(rf_we),    64'(0));

        // Scoreboard: re-issue on the clearing edge keeps the bit set.
        @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        @(posedge clk); #1;
        check("sb2_set7", 64'(busy_vec), 64'(32'h80));
        @(negedge clk); drive(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(posedge clk); #1;
        check("sb2_we", 64'(rf_we), 64'(1));
        @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        @(posedge clk); #1;
        check("sb2_set_wins", 64'(busy_vec), 64'(32'h80));
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        check("sb2_hold", 64'(busy_vec), 64'(32'h80));

        // x0 write and x0 issue leave the scoreboard alone.
        @(negedge clk); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0);
        #1;
        check("x0_rdy1", 64'(req1_ready), 64'(1));
        @(posedge clk); #1;
        check("x0_we",   64'(rf_we),    64'(0));
        check("x0_busy", 64'(busy_vec), 64'(32'h80));
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        check("x0_busy2", 64'(busy_vec), 64'(32'h80));

        // Asynchronous reset while a write is in flight.
        @(negedge clk); drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        @(posedge clk); #1;
        check("rst_pre_we",   64'(rf_we),    64'(1));
        check("rst_pre_busy", 64'(busy_vec), 64'(32'h280));
        drive_idle();
        #1;
        reset = 1'b0;
        #1;
        check("rst_we",    64'(rf_we),    64'(0));
        check("rst_waddr", 64'(rf_waddr), 64'(0));
        check("rst_wdata", 64'(rf_wdata), 64'(0));
        check("rst_busy",  64'(busy_vec), 64'(0));
        @(negedge clk); reset = 1'b1;
        @(negedge clk); drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0);
        #1;
        check("rst_pri_rdy0", 64'(req0_ready), 64'(1));
        check("rst_pri_rdy1", 64'(req1_ready), 64'(0));

        // Randomized traffic against the reference model.
        do_reset();
        m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_last = 1;
        p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        for (int c = 0; c < 3000; c++) begin
            int              w;
            logic            iv;
            logic [AW-1:0]   ia;
            logic [NREG-1:0] n_busy;
            @(negedge clk);
            if (!p0v && ($urandom_range(0, 2) != 0)) begin
                p0v = 1'b1;
                p0a = AW'($urandom_range(0, 7));
                p0d = $urandom;
            end
            if (!p1v && ($urandom_range(0, 2) != 0)) begin
                p1v = 1'b1;
                p1a = AW'($urandom_range(0, 7));
                p1d = $urandom;
            end
            iv = 1'($urandom_range(0, 1));
            ia = AW'($urandom_range(0, 7));
            drive(p0v, p0a, p0d, p1v, p1a, p1d, iv, ia);
            #1;
            // Who should win this cycle.
            w = -1;
            if (p0v && p1v) begin
`ifdef FB_WB_RR_EN
                w = (m_last == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else if (p0v) begin
                w = 0;
            end else if (p1v) begin
                w = 1;
            end
            check("rnd_rdy0",  64'(req0_ready), 64'(w == 0));
            check("rnd_rdy1",  64'(req1_ready), 64'(w == 1));
            check("rnd_we",    64'(rf_we),      64'(m_we));
            check("rnd_waddr", 64'(rf_waddr),   64'(m_waddr));
            check("rnd_wdata", 64'(rf_wdata),   64'(m_wdata));
            check("rnd_busy",  64'(busy_vec),   64'(m_busy));
            // Advance the model across the coming edge.
            n_busy = m_busy;
            if (m_we) n_busy[m_waddr] = 1'b0;
            if (iv && (ia != '0)) n_busy[ia] = 1'b1;
            m_busy = n_busy;
            if (w == 0) begin
                m_we = (p0a != '0); m_waddr = p0a; m_wdata = p0d; m_last = 0; p0v = 1'b0;
            end else if (w == 1) begin
                m_we = (p1a != '0); m_waddr = p1a; m_wdata = p1d; m_last = 1; p1v = 1'b0;
            end else begin
                m_we = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fb_rf_wr_arbiter.md
Name: fb_rf_wr_arbiter

Overview:
- Shares the single register-file write port (we/waddr/wdata) between two write-back requesters: req0 (ALU) and req1 (load unit).
- Arbitrates with a valid/ready handshake, registers the winning write and drives the regfile write port one cycle later.
- Maintains a per-register pending-write scoreboard (busy_vec) for the issue stage.
- Sits between the execute/memory stages and fb_regfile.

Parameters:
- XLEN, 32, data width of write values
- AW, 5, register address width; NREG = 2**AW

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous reset, active-low (0 = reset)
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  AW  requester 0 destination register
- req0_data  in  XLEN  requester 0 write value
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid  in  1  requester 1 has a write pending
- req1_addr  in  AW  requester 1 destination register
- req1_data  in  XLEN  requester 1 write value
- req1_ready  out  1  requester 1 write accepted this cycle
- issue_valid  in  1  an instruction with destination issue_addr issues this cycle
- issue_addr  in  AW  destination of the issuing instruction
- rf_we  out  1  to regfile we
- rf_waddr  out  AW  to regfile waddr
- rf_wdata  out  XLEN  to regfile wdata
- busy_vec  out  NREG  bit i = write to register i outstanding

Behaviour:
- Reset (reset=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, priority state = PRI0. req*_ready are combinational and evaluate to 0 while no valid is present.
- Handshake:
  - Transfer occurs when valid=1 and ready=1 on the same rising edge.
  - A requester holds valid, addr and data stable until ready.
  - ready is combinational from the valid inputs and the priority state; ready never depends on ready.
  - At most one ready is high per cycle.
- Arbitration FSM, two states:
  - PRI0: req0 wins if valid, otherwise req1 wins.
  - PRI1: mirror of PRI0 (req1 first, then req0).
  - After a grant to req0, next state = PRI1; after a grant to req1, next state = PRI0. No grant: state holds.
  - Only one valid: that requester is granted immediately in either state.
- Output stage:
  - On a transfer: rf_waddr and rf_wdata are loaded with the winner's addr/data; rf_we is set to 1 unless addr == 0.
  - No transfer: rf_we = 0; rf_waddr and rf_wdata hold their values.
  - Latency: handshake in cycle N, regfile write at edge N+1. Throughput is one write per cycle.
- x0 rule: a write to address 0 is accepted (ready asserted) but never drives rf_we.
- Scoreboard:
  - issue_valid with issue_addr != 0 sets busy_vec[issue_addr] at the next edge.
  - rf_we=1 clears busy_vec[rf_waddr] at the edge following the write cycle; the clear is registered with the output stage.
  - Same register set and cleared on the same edge: set wins, because a newer producer is outstanding.
  - busy_vec[0] is always 0.
  - Write to a non-busy register: performed normally, no error.
- Reset mid-operation: all state clears immediately, including in-flight registered writes. Requesters re-present after reset is released.

Optional Feature:
- Macro: FB_WB_RR_EN.
- Defined: round-robin PRI0/PRI1 FSM as described above.
- Undefined: fixed priority, req0 always wins and the state register is removed. req1 is granted only when req0_valid=0, so starvation of req1 is permitted.

Test Plan:
- Reset release, no requests: rf_we=0, busy_vec=0, both ready=0 for 5 cycles.
- req0 alone, addr=5'h08, data=32'h00000004: req0_ready=1 in cycle N; rf_we=1, rf_waddr=8, rf_wdata=4 in cycle N+1; rf_we=0 in N+2.
- Both valid continuously with addrs 3/4 and data A/B: grants alternate 0,1,0,1 (FB_WB_RR_EN defined); with the macro undefined, req0 is granted every cycle and req1_ready stays 0.
- req1 write to x0, data=32'hDEADBEEF: req1_ready=1, rf_we stays 0, busy_vec unchanged.
- Scoreboard:
  - issue_addr=7: busy_vec[7]=1 next cycle.
  - req0 write to 7: busy_vec[7] clears one edge after rf_we.
  - Re-issue of 7 on that same clearing edge: busy_vec[7] remains 1.
- Assert reset=0 while rf_we=1: rf_we, busy_vec and the FSM clear asynchronously before the next clock edge.
